// File: rtl/serial_neuron_mac.sv
// serial_neuron_mac: bit-serial neuron, one weight per cycle, act(bias + sum x*w) with saturation
module serial_neuron_mac #(
  parameter int N_INPUTS  = 4,
  parameter int W_WIDTH   = 8,
  parameter int OUT_WIDTH = 10,
  parameter int RELU_EN   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [N_INPUTS-1:0]           x_i,
  input  logic [N_INPUTS*W_WIDTH-1:0]   w_i,
  input  logic signed [W_WIDTH-1:0]     bias_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic signed [OUT_WIDTH-1:0]   neuron_o
);
  localparam int ACC_W = W_WIDTH + $clog2(N_INPUTS) + 1;
  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int SW    = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);
  localparam logic signed [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_O = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] OUT_MAX = SW'(MAX_O);
  localparam logic signed [SW-1:0] OUT_MIN = SW'(MIN_O);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                      state_q, state_d;
  logic [N_INPUTS-1:0]         x_q;
  logic [N_INPUTS*W_WIDTH-1:0] w_q;
  logic [IDX_W-1:0]            idx;
  logic signed [ACC_W-1:0]     acc, sum_next;
  logic signed [SW-1:0]        sum_w;
  logic [W_WIDTH-1:0]          w_sel;
  logic                        last, over, under;
  logic signed [OUT_WIDTH-1:0] result;

  assign ready_o  = rst_i & en_i & (state_q == IDLE);
  assign last     = (idx == LAST);
  assign w_sel    = w_q[int'(idx)*W_WIDTH +: W_WIDTH];
  assign sum_next = acc + (x_q[idx] ? ACC_W'($signed(w_sel)) : ACC_W'(0));
  assign sum_w    = SW'(sum_next);
  assign over     = sum_w > OUT_MAX;
  // ReLU moves the lower clamp to zero
  assign under    = (RELU_EN != 0) ? (sum_w < 0) : (sum_w < OUT_MIN);
  assign result   = under ? ((RELU_EN != 0) ? '0 : MIN_O) : over ? MAX_O : sum_w[OUT_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    if (en_i)
      state_d = (state_q == IDLE && valid_i)  ? ACCUM :
                (state_q == ACCUM && last)    ? DONE  :
                (state_q == DONE && ready_i)  ? IDLE  : state_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q      <= '0;
      w_q      <= '0;
      idx      <= '0;
      acc      <= '0;
      valid_o  <= 1'b0;
      neuron_o <= '0;
    end else if (en_i) begin
      if (state_q == IDLE && valid_i) begin
        x_q <= x_i;
        w_q <= w_i;
        acc <= ACC_W'(bias_i);
        idx <= '0;
      end else if (state_q == ACCUM) begin
        acc <= sum_next;
        idx <= idx + 1'b1;
        if (last) begin
          neuron_o <= result;
          valid_o  <= 1'b1;
        end
      end else if (state_q == DONE && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_neuron_mac.sv
// tb_serial_neuron_mac: directed checks of ReLU and linear builds driven side by side
module tb_serial_neuron_mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        vin = 1'b0;
  logic        rdy_in = 1'b0;
  logic [3:0]  x = '0;
  logic [31:0] w = '0;
  logic [7:0]  b = '0;
  logic        ready_r, valid_r, ready_l, valid_l;
  logic [9:0]  neu_r, neu_l;
  int          passed = 0;
  int          total = 0;
  int          lat;

  always #5 clk = ~clk;

  serial_neuron_mac #(.RELU_EN(1)) dut_r (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .valid_i(vin), .ready_o(ready_r),
    .x_i(x), .w_i(w), .bias_i(b), .valid_o(valid_r), .ready_i(rdy_in), .neuron_o(neu_r));

  serial_neuron_mac #(.RELU_EN(0)) dut_l (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .valid_i(vin), .ready_o(ready_l),
    .x_i(x), .w_i(w), .bias_i(b), .valid_o(valid_l), .ready_i(rdy_in), .neuron_o(neu_l));

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pk(input int w3, input int w2, input int w1, input int w0);
    return {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] xv, input logic [31:0] wv, input int bv);
    x = xv; w = wv; b = 8'(bv); vin = 1'b1;
    tick();
    vin = 1'b0; x = 4'($urandom); w = $urandom; b = 8'($urandom);
  endtask

  task automatic wait_valid(input int stall, output int l);
    l = 0;
    while (!valid_r && l < 40) begin
      en = !(stall > 0 && l >= 1 && l < 1 + stall);
      tick();
      l++;
    end
    en = 1'b1;
  endtask

  task automatic take();
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk("handoff_valid", {9'd0, valid_r}, 10'd0);
    chk("handoff_ready", {9'd0, ready_r}, 10'd1);
  endtask

  task automatic run(input string tag, input logic [3:0] xv, input logic [31:0] wv, input int bv,
                     input int exp_r, input int exp_l);
    send(xv, wv, bv);
    wait_valid(0, lat);
    chk({tag, "_lat"}, 10'(lat), 10'd4);
    chk({tag, "_relu"}, neu_r, 10'(exp_r));
    chk({tag, "_lin"}, neu_l, 10'(exp_l));
    take();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_ready", {9'd0, ready_r}, 10'd0);
    chk("rst_valid", {9'd0, valid_r}, 10'd0);
    chk("rst_neuron", neu_r, 10'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", {9'd0, ready_r}, 10'd1);
    en = 1'b0;
    #1;
    chk("idle_ready_en_low", {9'd0, ready_r}, 10'd0);
    en = 1'b1;
    tick();

    run("half", 4'b1111, pk(64, 64, 64, 64), 0, 256, 256);
    run("mixed", 4'b0101, pk(10, -100, 20, 30), -5, 0, -75);
    run("sat_hi", 4'b1111, pk(127, 127, 127, 127), 127, 511, 511);
    run("sat_lo", 4'b1111, pk(-128, -128, -128, -128), -128, 0, -512);
    run("x_zero_neg", 4'b0000, pk(50, 50, 50, 50), -7, 0, -7);
    run("x_zero_pos", 4'b0000, pk(-50, -50, -50, -50), 100, 100, 100);

    send(4'b0011, pk(90, 90, 2, 1), 3);
    wait_valid(0, lat);
    chk("bp_lat", 10'(lat), 10'd4);
    x = 4'b1111; w = pk(100, 100, 100, 100); b = 8'd100; vin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {9'd0, valid_r}, 10'd1);
      chk("bp_neuron", neu_r, 10'd6);
      chk("bp_ready", {9'd0, ready_r}, 10'd0);
    end
    vin = 1'b0;
    take();
    run("after_bp", 4'b1000, pk(-20, 0, 0, 0), 8, 0, -12);

    send(4'b1110, pk(40, 30, 20, 10), 1);
    wait_valid(3, lat);
    chk("stall_lat", 10'(lat), 10'd7);
    chk("stall_relu", neu_r, 10'd91);
    chk("stall_lin", neu_l, 10'd91);
    en = 1'b0; rdy_in = 1'b1;
    tick();
    chk("en_low_hold_valid", {9'd0, valid_r}, 10'd1);
    chk("en_low_hold_neuron", neu_r, 10'd91);
    en = 1'b1; rdy_in = 1'b0;
    take();

    send(4'b1111, pk(1, 1, 1, 1), 0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {9'd0, valid_r}, 10'd0);
    chk("arst_neuron", neu_r, 10'd0);
    chk("arst_ready", {9'd0, ready_r}, 10'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready", {9'd0, ready_r}, 10'd1);
    run("post_rst", 4'b0110, pk(5, -30, 12, 99), 4, 0, -14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
